mod_regread: RTL and testbench
==============================

// Module: mod_regread
// PURPOSE
//  Register-read / scoreboard stage, the consumer end of the writeback path.
//  Holds the 16x64 architectural register file and serves two source operands to the issue stage.
//  Accepts up to two writes per cycle from writeback, e.g. MUL (opcode 247) writes RAX=reg0 and RDX=reg2.
//  Tracks pending destinations with busy bits, so RAW/WAW hazards stall issue, and forwards same-cycle writes.
// PARAMETERS
//  NREGS  16  number of architectural registers (index width = $clog2(NREGS))
//  XLEN   64  register width
//  CNT_W  32  stall-counter width
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  rd_valid     in   1      issue stage presents an instruction
//  rd_srcA      in   4      source register A index
//  rd_srcB      in   4      source register B index
//  rd_dst_we    in   1      instruction will write rd_dst
//  rd_dst       in   4      destination index
//  rd_dst2_we   in   1      instruction also writes reg 2 (MUL extended result)
//  rd_dataA     out  XLEN   operand A (combinational, bypassed)
//  rd_dataB     out  XLEN   operand B (combinational, bypassed)
//  rd_ready     out  1      issue accepted this cycle
//  wb_we0       in   1      write port 0 enable
//  wb_idx0      in   4      write port 0 index
//  wb_data0     in   XLEN   write port 0 data
//  wb_we1       in   1      write port 1 enable
//  wb_idx1      in   4      write port 1 index
//  wb_data1     in   XLEN   write port 1 data
//  busy         out  NREGS  registered pending-write bit per register
//  stall_cnt    out  CNT_W  cycles with rd_valid=1 and rd_ready=0, saturating
//  wb_err       out  1      sticky: a write hit a register whose busy bit was 0
// BEHAVIOUR
//  - Reset (reset_n=0, async): all regs=0, busy=0, stall_cnt=0, wb_err=0. Outputs follow immediately.
//  - Write: on posedge, port k with wb_wek=1 stores wb_datak and clears busy[wb_idxk].
//    If both ports write the same index, port 1 data wins and busy is cleared once.
//  - Read: rd_dataX = regs[srcX], bypassed to wb_data1 if port 1 writes srcX this cycle, else wb_data0 if port 0 does.
//    Zero-latency read.
//  - Source hazard: srcX is blocked iff busy[srcX]=1 and no write port targets srcX this cycle.
//    An unused source still checks; decode points it at a non-busy register.
//  - Destination hazard: blocked iff busy[rd_dst]=1 (rd_dst_we) or busy[2]=1 (rd_dst2_we),
//    unless cleared by a same-cycle write.
//  - rd_ready = rd_valid & no source hazard & no destination hazard.
//  - On accept: busy[rd_dst] is set (if rd_dst_we), and busy[2] is set (if rd_dst2_we).
//    If the same register is also cleared by writeback this cycle, set wins.
//  - stall_cnt: increments when rd_valid & ~rd_ready; holds at all-ones.
//  - wb_err: sets when wb_wek=1 and busy[wb_idxk]=0 before the edge; cleared only by reset.
//  - Reset mid-operation discards all pending busy state; the pipeline flushes alongside.
//  - Writes with rd_valid=0 still update regs and busy.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - EX_WB struct.
//    - Opcode constants: OPC_MUL=8'd247, OPC_STORE=8'd137, OPC_LOAD=8'd139.
//    - REG_RAX=0, REG_RDX=2, NREGS, XLEN.
//  - Sub-module mod_scoreboard: busy vector, hazard check, set/clear arbitration, stall_cnt, wb_err.
//  - mod_regread keeps the storage array and the bypass muxes.
// TESTING
//  1. Reset, then rd_valid srcA=3 srcB=4 -> rd_dataA=rd_dataB=0, rd_ready=1, busy=0.
//  2. wb_we0 idx=5 data=64'hDEAD_BEEF. Next cycle read srcA=5 -> 64'hDEAD_BEEF.
//     wb_err=1 because busy[5] was 0.
//  3. Issue dst=7, busy[7]=1. Next instr srcA=7 -> rd_ready=0, stall_cnt increments each cycle.
//     Same cycle as wb_we0 idx=7 data=42 -> rd_ready=1, rd_dataA=42.
//  4. Issue with rd_dst_we dst=0 and rd_dst2_we -> busy[0]=busy[2]=1.
//     Then wb0 idx0=0 data=6 with wb1 idx1=2 data=1 -> both busy cleared, regs[0]=6, regs[2]=1, wb_err=0.
//  5. Both ports write idx 9 (data 1 vs 2) -> regs[9]=2.
//     Same-cycle issue of dst=9 with a write to 9 -> busy[9]=1 after the edge.
//  6. Set busy[1], regs[1]=5, then assert reset_n=0 mid-cycle -> busy=0, regs[1]=0, stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural sizes, opcode constants, the EX->WB
// transfer record and the operand-bypass selector used by register read.
package cpu_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned IDX_W = $clog2(NREGS);

  localparam logic [7:0] OPC_MUL   = 8'd247;
  localparam logic [7:0] OPC_STORE = 8'd137;
  localparam logic [7:0] OPC_LOAD  = 8'd139;

  // MUL writes its low half to RAX and its high half to RDX.
  localparam logic [IDX_W-1:0] REG_RAX = IDX_W'(0);
  localparam logic [IDX_W-1:0] REG_RDX = IDX_W'(2);

  // Result record handed from execute to writeback; up to two results per op.
  typedef struct packed {
    logic             valid;
    logic [7:0]       opcode;
    logic             we0;
    logic [IDX_W-1:0] idx0;
    logic [XLEN-1:0]  data0;
    logic             we1;
    logic [IDX_W-1:0] idx1;
    logic [XLEN-1:0]  data1;
  } ex_wb_t;

  // Where a source operand is taken from this cycle.
  typedef enum logic [1:0] {
    BYP_REG = 2'd0,
    BYP_WB0 = 2'd1,
    BYP_WB1 = 2'd2
  } byp_sel_e;

endpackage

// File: rtl/mod_scoreboard.sv
// Scoreboard: per-register busy bits, RAW/WAW hazard detection, set/clear
// arbitration, saturating stall counter and sticky unexpected-write flag.
module mod_scoreboard #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rd_valid,
  input  logic [$clog2(NREGS)-1:0] rd_srcA,
  input  logic [$clog2(NREGS)-1:0] rd_srcB,
  input  logic                     rd_dst_we,
  input  logic [$clog2(NREGS)-1:0] rd_dst,
  input  logic                     rd_dst2_we,
  input  logic                     wb_we0,
  input  logic [$clog2(NREGS)-1:0] wb_idx0,
  input  logic                     wb_we1,
  input  logic [$clog2(NREGS)-1:0] wb_idx1,
  output logic                     rd_ready,
  output logic [NREGS-1:0]         busy,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     wb_err
);
  import cpu_pkg::*;

  logic [NREGS-1:0] r_busy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_wb_err;

  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_blk_a;
  logic             w_blk_b;
  logic             w_blk_d;
  logic             w_blk_d2;
  logic             w_ready;
  logic             w_err_hit;

  // Registers being written back this cycle; a write to the same index from
  // both ports collapses onto a single clear.
  always_comb begin
    w_clr = '0;
    if (wb_we0) w_clr[wb_idx0] = 1'b1;
    if (wb_we1) w_clr[wb_idx1] = 1'b1;
  end

  // Hazard check: a busy register is usable only if writeback frees it now.
  always_comb begin
    w_blk_a  = r_busy[rd_srcA] & ~w_clr[rd_srcA];
    w_blk_b  = r_busy[rd_srcB] & ~w_clr[rd_srcB];
    w_blk_d  = rd_dst_we  & r_busy[rd_dst]  & ~w_clr[rd_dst];
    w_blk_d2 = rd_dst2_we & r_busy[REG_RDX] & ~w_clr[REG_RDX];
    w_ready  = rd_valid & ~(w_blk_a | w_blk_b | w_blk_d | w_blk_d2);
  end

  // Next busy vector: clear on writeback, then set on accept so set wins.
  always_comb begin
    w_set = '0;
    if (w_ready && rd_dst_we)  w_set[rd_dst]  = 1'b1;
    if (w_ready && rd_dst2_we) w_set[REG_RDX] = 1'b1;
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  // A writeback to a register with no pending producer is a protocol error.
  always_comb begin
    w_err_hit = (wb_we0 & ~r_busy[wb_idx0]) | (wb_we1 & ~r_busy[wb_idx1]);
  end

  // Busy bit storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  // Stall counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (rd_valid && !w_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_wb_err <= 1'b0;
    else if (w_err_hit) r_wb_err <= 1'b1;
  end

  assign rd_ready  = w_ready;
  assign busy      = r_busy;
  assign stall_cnt = r_stall_cnt;
  assign wb_err    = r_wb_err;

endmodule

// File: rtl/mod_regread.sv
// Register-read stage: 16x64 architectural register file with two writeback
// ports and two bypassed read ports; hazard tracking lives in mod_scoreboard.
module mod_regread #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rd_valid,
  input  logic [$clog2(NREGS)-1:0] rd_srcA,
  input  logic [$clog2(NREGS)-1:0] rd_srcB,
  input  logic                     rd_dst_we,
  input  logic [$clog2(NREGS)-1:0] rd_dst,
  input  logic                     rd_dst2_we,
  output logic [XLEN-1:0]          rd_dataA,
  output logic [XLEN-1:0]          rd_dataB,
  output logic                     rd_ready,
  input  logic                     wb_we0,
  input  logic [$clog2(NREGS)-1:0] wb_idx0,
  input  logic [XLEN-1:0]          wb_data0,
  input  logic                     wb_we1,
  input  logic [$clog2(NREGS)-1:0] wb_idx1,
  input  logic [XLEN-1:0]          wb_data1,
  output logic [NREGS-1:0]         busy,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     wb_err
);
  import cpu_pkg::*;

  logic [XLEN-1:0] r_regs [NREGS];
  byp_sel_e        w_sel_a;
  byp_sel_e        w_sel_b;

  // Register file write; port 1 is applied last so it wins on a shared index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (wb_we0) r_regs[wb_idx0] <= wb_data0;
      if (wb_we1) r_regs[wb_idx1] <= wb_data1;
    end
  end

  // Bypass source selection, port 1 taking priority over port 0.
  always_comb begin
    w_sel_a = BYP_REG;
    w_sel_b = BYP_REG;
    if (wb_we0 && (wb_idx0 == rd_srcA)) w_sel_a = BYP_WB0;
    if (wb_we1 && (wb_idx1 == rd_srcA)) w_sel_a = BYP_WB1;
    if (wb_we0 && (wb_idx0 == rd_srcB)) w_sel_b = BYP_WB0;
    if (wb_we1 && (wb_idx1 == rd_srcB)) w_sel_b = BYP_WB1;
  end

  // Operand muxes: zero-latency read of storage or same-cycle writeback data.
  always_comb begin
    rd_dataA = r_regs[rd_srcA];
    rd_dataB = r_regs[rd_srcB];
    case (w_sel_a)
      BYP_WB0: rd_dataA = wb_data0;
      BYP_WB1: rd_dataA = wb_data1;
      default: rd_dataA = r_regs[rd_srcA];
    endcase
    case (w_sel_b)
      BYP_WB0: rd_dataB = wb_data0;
      BYP_WB1: rd_dataB = wb_data1;
      default: rd_dataB = r_regs[rd_srcB];
    endcase
  end

  mod_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_valid   (rd_valid),
    .rd_srcA    (rd_srcA),
    .rd_srcB    (rd_srcB),
    .rd_dst_we  (rd_dst_we),
    .rd_dst     (rd_dst),
    .rd_dst2_we (rd_dst2_we),
    .wb_we0     (wb_we0),
    .wb_idx0    (wb_idx0),
    .wb_we1     (wb_we1),
    .wb_idx1    (wb_idx1),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .stall_cnt  (stall_cnt),
    .wb_err     (wb_err)
  );

endmodule

// File: tb/tb_mod_regread.sv
// Testbench for mod_regread: directed vector table, hand-written async reset
// sequence, then randomized traffic against a behavioural model.
module tb_mod_regread;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic [3:0]  rd_srcA = '0, rd_srcB = '0, rd_dst = '0;
  logic        rd_dst_we = 1'b0, rd_dst2_we = 1'b0;
  logic        wb_we0 = 1'b0, wb_we1 = 1'b0;
  logic [3:0]  wb_idx0 = '0, wb_idx1 = '0;
  logic [63:0] wb_data0 = '0, wb_data1 = '0;

  logic [63:0] rd_dataA, rd_dataB;
  logic        rd_ready;
  logic [15:0] busy;
  logic [31:0] stall_cnt;
  logic        wb_err;

  // Second instance with a 3-bit counter so saturation is reachable.
  logic [63:0] s_dataA, s_dataB;
  logic        s_ready, s_err;
  logic [15:0] s_busy;
  logic [2:0]  s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod_regread #(.NREGS(16), .XLEN(64), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid), .rd_srcA(rd_srcA),
    .rd_srcB(rd_srcB), .rd_dst_we(rd_dst_we), .rd_dst(rd_dst),
    .rd_dst2_we(rd_dst2_we), .rd_dataA(rd_dataA), .rd_dataB(rd_dataB),
    .rd_ready(rd_ready), .wb_we0(wb_we0), .wb_idx0(wb_idx0),
    .wb_data0(wb_data0), .wb_we1(wb_we1), .wb_idx1(wb_idx1),
    .wb_data1(wb_data1), .busy(busy), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  mod_regread #(.NREGS(16), .XLEN(64), .CNT_W(3)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid), .rd_srcA(rd_srcA),
    .rd_srcB(rd_srcB), .rd_dst_we(rd_dst_we), .rd_dst(rd_dst),
    .rd_dst2_we(rd_dst2_we), .rd_dataA(s_dataA), .rd_dataB(s_dataB),
    .rd_ready(s_ready), .wb_we0(wb_we0), .wb_idx0(wb_idx0),
    .wb_data0(wb_data0), .wb_we1(wb_we1), .wb_idx1(wb_idx1),
    .wb_data1(wb_data1), .busy(s_busy), .stall_cnt(s_cnt), .wb_err(s_err)
  );

  typedef struct {
    logic        v;
    logic [3:0]  a, b;
    logic        dwe;
    logic [3:0]  d;
    logic        d2;
    logic        we0;
    logic [3:0]  i0;
    logic [63:0] x0;
    logic        we1;
    logic [3:0]  i1;
    logic [63:0] x1;
    logic        rdy;
    logic [63:0] ea, eb;
    logic [15:0] ebusy;
    logic [31:0] ecnt;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input logic [3:0] a, input logic [3:0] b,
    input logic dwe, input logic [3:0] d, input logic d2,
    input logic we0, input logic [3:0] i0, input logic [63:0] x0,
    input logic we1, input logic [3:0] i1, input logic [63:0] x1,
    input logic rdy, input logic [63:0] ea, input logic [63:0] eb,
    input logic [15:0] ebusy, input logic [31:0] ecnt, input logic eerr);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.dwe = dwe; t.d = d; t.d2 = d2;
    t.we0 = we0; t.i0 = i0; t.x0 = x0; t.we1 = we1; t.i1 = i1; t.x1 = x1;
    t.rdy = rdy; t.ea = ea; t.eb = eb; t.ebusy = ebusy; t.ecnt = ecnt;
    t.eerr = eerr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    rd_valid = 1'b0; rd_srcA = '0; rd_srcB = '0; rd_dst_we = 1'b0;
    rd_dst = '0; rd_dst2_we = 1'b0; wb_we0 = 1'b0; wb_idx0 = '0;
    wb_data0 = '0; wb_we1 = 1'b0; wb_idx1 = '0; wb_data1 = '0;
  endtask

  // Behavioural model state
  logic [63:0] m_regs [16];
  logic [15:0] m_busy;
  int unsigned m_cnt;
  int unsigned m_sat;
  logic        m_err;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0; m_cnt = 0; m_sat = 0; m_err = 1'b0;
  endtask

  function automatic bit hit(input int r);
    return (wb_we0 && wb_idx0 == r) || (wb_we1 && wb_idx1 == r);
  endfunction

  function automatic logic [63:0] view(input int r);
    if (wb_we1 && wb_idx1 == r) return wb_data1;
    if (wb_we0 && wb_idx0 == r) return wb_data0;
    return m_regs[r];
  endfunction

  function automatic bit blocked(input int r);
    return m_busy[r] && !hit(r);
  endfunction

  function automatic int pick_idx();
    int start;
    if (m_busy != 0 && $urandom_range(0, 3) != 0) begin
      start = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++)
        if (m_busy[(start + k) % 16]) return (start + k) % 16;
    end
    return $urandom_range(0, 7);
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(1,3,4, 0,0,0, 0,0,0,            0,0,0, 1, 0,0, 16'h0000,0,0);
    tbl[1]  = mk(1,0,0, 1,7,0, 0,0,0,            0,0,0, 1, 0,0, 16'h0080,0,0);
    tbl[2]  = mk(1,7,0, 0,0,0, 0,0,0,            0,0,0, 0, 0,0, 16'h0080,1,0);
    tbl[3]  = mk(1,7,0, 0,0,0, 0,0,0,            0,0,0, 0, 0,0, 16'h0080,2,0);
    tbl[4]  = mk(1,7,0, 0,0,0, 1,7,42,           0,0,0, 1, 42,0, 16'h0000,2,0);
    tbl[5]  = mk(1,7,1, 1,0,1, 0,0,0,            0,0,0, 1, 42,0, 16'h0005,2,0);
    tbl[6]  = mk(1,0,2, 0,0,0, 1,0,6,            1,2,1, 1, 6,1, 16'h0000,2,0);
    tbl[7]  = mk(1,0,2, 0,0,0, 0,0,0,            0,0,0, 1, 6,1, 16'h0000,2,0);
    tbl[8]  = mk(0,0,0, 0,0,0, 1,5,64'hDEADBEEF, 0,0,0, 0, 6,6, 16'h0000,2,1);
    tbl[9]  = mk(1,5,0, 0,0,0, 0,0,0,   0,0,0, 1, 64'hDEADBEEF,6, 16'h0000,2,1);
    tbl[10] = mk(0,9,9, 0,0,0, 1,9,1,            1,9,2, 0, 2,2, 16'h0000,2,1);
    tbl[11] = mk(1,9,9, 0,0,0, 0,0,0,            0,0,0, 1, 2,2, 16'h0000,2,1);
    tbl[12] = mk(1,0,0, 1,9,0, 0,0,0,            0,0,0, 1, 6,6, 16'h0200,2,1);
    tbl[13] = mk(1,0,0, 1,9,0, 1,9,3,            0,0,0, 1, 6,6, 16'h0200,2,1);
    tbl[14] = mk(1,9,0, 0,0,0, 0,0,0,            0,0,0, 0, 3,6, 16'h0200,3,1);
    tbl[15] = mk(1,0,0, 1,9,0, 0,0,0,            0,0,0, 0, 6,6, 16'h0200,4,1);
    tbl[16] = mk(1,0,0, 0,0,1, 0,0,0,            0,0,0, 1, 6,6, 16'h0204,4,1);
    tbl[17] = mk(1,0,0, 0,0,1, 0,0,0,            0,0,0, 0, 6,6, 16'h0204,5,1);

    // Reset state
    drive_idle();
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_cnt", 64'(stall_cnt), 64'h0);
    chk("reset_err", 64'(wb_err), 64'h0);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rd_valid = tbl[i].v; rd_srcA = tbl[i].a; rd_srcB = tbl[i].b;
      rd_dst_we = tbl[i].dwe; rd_dst = tbl[i].d; rd_dst2_we = tbl[i].d2;
      wb_we0 = tbl[i].we0; wb_idx0 = tbl[i].i0; wb_data0 = tbl[i].x0;
      wb_we1 = tbl[i].we1; wb_idx1 = tbl[i].i1; wb_data1 = tbl[i].x1;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(rd_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_dataA", i), rd_dataA, tbl[i].ea);
      chk($sformatf("v%0d_dataB", i), rd_dataB, tbl[i].eb);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].ebusy));
      chk($sformatf("v%0d_cnt", i), 64'(stall_cnt), 64'(tbl[i].ecnt));
      chk($sformatf("v%0d_err", i), 64'(wb_err), 64'(tbl[i].eerr));
    end

    // Async reset in the middle of a cycle with pending state
    @(negedge clk);
    drive_idle();
    wb_we0 = 1'b1; wb_idx0 = 4'd1; wb_data0 = 64'd5;
    @(negedge clk);
    drive_idle();
    rd_valid = 1'b1; rd_srcA = 4'd1; rd_dst_we = 1'b1; rd_dst = 4'd1;
    @(posedge clk); #1;
    rd_valid = 1'b0; rd_dst_we = 1'b0;
    #1;
    chk("pre_rst_busy1", 64'(busy[1]), 64'h1);
    chk("pre_rst_reg1", rd_dataA, 64'd5);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_reg1", rd_dataA, 64'h0);
    chk("rst_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_err", 64'(wb_err), 64'h0);
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit   exp_rdy;
      logic [15:0] nb;
      @(negedge clk);
      chk("rnd_busy", 64'(busy), 64'(m_busy));
      chk("rnd_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("rnd_sat", 64'(s_cnt), 64'(m_sat));
      chk("rnd_err", 64'(wb_err), 64'(m_err));
      rd_valid   = ($urandom_range(0, 3) != 0);
      rd_srcA    = 4'($urandom_range(0, 7));
      rd_srcB    = 4'($urandom_range(0, 7));
      rd_dst_we  = $urandom_range(0, 1) == 1;
      rd_dst     = 4'($urandom_range(0, 7));
      rd_dst2_we = ($urandom_range(0, 7) == 0);
      wb_we0     = ($urandom_range(0, 9) < 4);
      wb_idx0    = 4'(pick_idx());
      wb_data0   = {$urandom, $urandom};
      wb_we1     = ($urandom_range(0, 9) < 2);
      wb_idx1    = 4'(pick_idx());
      wb_data1   = {$urandom, $urandom};
      #1;
      exp_rdy = rd_valid && !blocked(rd_srcA) && !blocked(rd_srcB) &&
                !(rd_dst_we && blocked(rd_dst)) && !(rd_dst2_we && blocked(2));
      chk("rnd_ready", 64'(rd_ready), 64'(exp_rdy));
      chk("rnd_dataA", rd_dataA, view(rd_srcA));
      chk("rnd_dataB", rd_dataB, view(rd_srcB));
      chk("rnd_sat_ready", 64'(s_ready), 64'(exp_rdy));
      // Model update for the coming edge
      if ((wb_we0 && !m_busy[wb_idx0]) || (wb_we1 && !m_busy[wb_idx1]))
        m_err = 1'b1;
      nb = m_busy;
      if (wb_we0) begin m_regs[wb_idx0] = wb_data0; nb[wb_idx0] = 1'b0; end
      if (wb_we1) begin m_regs[wb_idx1] = wb_data1; nb[wb_idx1] = 1'b0; end
      if (exp_rdy && rd_dst_we)  nb[rd_dst] = 1'b1;
      if (exp_rdy && rd_dst2_we) nb[2] = 1'b1;
      m_busy = nb;
      if (rd_valid && !exp_rdy) begin
        m_cnt++;
        if (m_sat < 7) m_sat++;
      end
    end
    @(negedge clk);
    chk("end_busy", 64'(busy), 64'(m_busy));
    chk("end_sat", 64'(s_cnt), 64'(m_sat));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
